// File: rtl/spi_flash_scheduler.sv
// Shares the byte-level SPI flash engine between the CPU port and the loader.
// Expands each request into READ, or WREN + PAGE PROGRAM + RDSR polling.
module spi_flash_scheduler #(
  parameter int POLL_GAP   = 16,
  parameter int POLL_LIMIT = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_rw,
  input  logic [23:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_err,
  input  logic        ldr_req,
  input  logic        ldr_rw,
  input  logic [23:0] ldr_addr,
  input  logic [7:0]  ldr_wdata,
  output logic        ldr_ack,
  output logic [7:0]  ldr_rdata,
  output logic        ldr_err,
  output logic        eng_start,
  output logic [1:0]  eng_op,
  output logic [7:0]  eng_cmd,
  output logic [23:0] eng_addr,
  output logic [7:0]  eng_wdata,
  input  logic        eng_done,
  input  logic [7:0]  eng_rdata,
  output logic        busy
);

  localparam int PW = $clog2(POLL_LIMIT + 1);
  localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [PW-1:0] LIMIT_W  = PW'(POLL_LIMIT);
  localparam logic [GW-1:0] GAP_LAST = GW'(POLL_GAP - 1);

  localparam logic [1:0] OP_CMD  = 2'd0;
  localparam logic [1:0] OP_RD   = 2'd1;
  localparam logic [1:0] OP_WR   = 2'd2;
  localparam logic [1:0] OP_STAT = 2'd3;

  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_WREN = 8'h06;
  localparam logic [7:0] CMD_PP   = 8'h02;
  localparam logic [7:0] CMD_RDSR = 8'h05;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_RD_ISSUE   = 4'd1,
    S_RD_WAIT    = 4'd2,
    S_WREN_ISSUE = 4'd3,
    S_WREN_WAIT  = 4'd4,
    S_PP_ISSUE   = 4'd5,
    S_PP_WAIT    = 4'd6,
    S_POLL_ISSUE = 4'd7,
    S_POLL_WAIT  = 4'd8,
    S_POLL_GAP   = 4'd9,
    S_FINISH     = 4'd10
  } state_t;

  state_t        r_state;
  logic          r_gnt_ldr;
  logic          r_rr_last;
  logic [23:0]   r_addr;
  logic [7:0]    r_wdata;
  logic [PW-1:0] r_poll_cnt;
  logic [GW-1:0] r_gap_cnt;

  logic          w_req_any;
  logic          w_pick_ldr;
  logic          w_sel_rw;
  logic [23:0]   w_sel_addr;
  logic [7:0]    w_sel_wdata;
  logic [PW-1:0] w_poll_next;
  logic          w_poll_more;

  // r_rr_last = 1 means the loader won the last grant, so the CPU wins a tie.
  assign w_req_any   = cpu_req | ldr_req;
  assign w_pick_ldr  = ldr_req & (~cpu_req | ~r_rr_last);
  assign w_sel_rw    = w_pick_ldr ? ldr_rw    : cpu_rw;
  assign w_sel_addr  = w_pick_ldr ? ldr_addr  : cpu_addr;
  assign w_sel_wdata = w_pick_ldr ? ldr_wdata : cpu_wdata;
  assign w_poll_next = r_poll_cnt + PW'(1);
  assign w_poll_more = (w_poll_next < LIMIT_W);

  // Sequencer: arbitration, command expansion, status polling and completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_gnt_ldr  <= 1'b0;
      r_rr_last  <= 1'b1;
      r_addr     <= 24'h000000;
      r_wdata    <= 8'h00;
      r_poll_cnt <= '0;
      r_gap_cnt  <= '0;
      cpu_ack    <= 1'b0;
      cpu_err    <= 1'b0;
      cpu_rdata  <= 8'h00;
      ldr_ack    <= 1'b0;
      ldr_err    <= 1'b0;
      ldr_rdata  <= 8'h00;
      eng_start  <= 1'b0;
      eng_op     <= OP_CMD;
      eng_cmd    <= 8'h00;
      eng_addr   <= 24'h000000;
      eng_wdata  <= 8'h00;
      busy       <= 1'b0;
    end else begin
      eng_start <= 1'b0;
      cpu_ack   <= 1'b0;
      cpu_err   <= 1'b0;
      ldr_ack   <= 1'b0;
      ldr_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req_any) begin
            r_gnt_ldr <= w_pick_ldr;
            r_rr_last <= w_pick_ldr;
            r_addr    <= w_sel_addr;
            r_wdata   <= w_sel_wdata;
            busy      <= 1'b1;
            eng_start <= 1'b1;
            eng_addr  <= w_sel_addr;
            eng_wdata <= w_sel_wdata;
            if (w_sel_rw) begin
              r_state <= S_RD_ISSUE;
              eng_op  <= OP_RD;
              eng_cmd <= CMD_READ;
            end else begin
              r_state <= S_WREN_ISSUE;
              eng_op  <= OP_CMD;
              eng_cmd <= CMD_WREN;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RD_ISSUE: r_state <= S_RD_WAIT;
        S_RD_WAIT: begin
          if (eng_done) begin
            if (r_gnt_ldr) begin
              ldr_rdata <= eng_rdata;
            end else begin
              cpu_rdata <= eng_rdata;
            end
            cpu_ack <= ~r_gnt_ldr;
            ldr_ack <= r_gnt_ldr;
            r_state <= S_FINISH;
          end else begin
            r_state <= S_RD_WAIT;
          end
        end
        S_WREN_ISSUE: r_state <= S_WREN_WAIT;
        S_WREN_WAIT: begin
          if (eng_done) begin
            r_state    <= S_PP_ISSUE;
            r_poll_cnt <= '0;
            eng_start  <= 1'b1;
            eng_op     <= OP_WR;
            eng_cmd    <= CMD_PP;
            eng_addr   <= r_addr;
            eng_wdata  <= r_wdata;
          end else begin
            r_state <= S_WREN_WAIT;
          end
        end
        S_PP_ISSUE: r_state <= S_PP_WAIT;
        S_PP_WAIT: begin
          if (eng_done) begin
            r_state   <= S_POLL_ISSUE;
            eng_start <= 1'b1;
            eng_op    <= OP_STAT;
            eng_cmd   <= CMD_RDSR;
          end else begin
            r_state <= S_PP_WAIT;
          end
        end
        S_POLL_ISSUE: r_state <= S_POLL_WAIT;
        S_POLL_WAIT: begin
          if (eng_done) begin
            r_poll_cnt <= w_poll_next;
            // WIP is status bit 0; give up once the poll budget is spent.
            if (!eng_rdata[0]) begin
              cpu_ack <= ~r_gnt_ldr;
              ldr_ack <= r_gnt_ldr;
              r_state <= S_FINISH;
            end else if (w_poll_more) begin
              r_gap_cnt <= '0;
              r_state   <= S_POLL_GAP;
            end else begin
              cpu_ack <= ~r_gnt_ldr;
              ldr_ack <= r_gnt_ldr;
              cpu_err <= ~r_gnt_ldr;
              ldr_err <= r_gnt_ldr;
              r_state <= S_FINISH;
            end
          end else begin
            r_state <= S_POLL_WAIT;
          end
        end
        S_POLL_GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_state   <= S_POLL_ISSUE;
            eng_start <= 1'b1;
            eng_op    <= OP_STAT;
            eng_cmd   <= CMD_RDSR;
          end else begin
            r_gap_cnt <= r_gap_cnt + GW'(1);
          end
        end
        S_FINISH: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_scheduler.sv
// Bench for spi_flash_scheduler: a fixed-latency engine stand-in, a cycle-level
// transaction model checked every cycle, and directed scenarios with literal expectations.
module tb_spi_flash_scheduler;
  localparam int GAP   = 16;
  localparam int LIMIT = 4;
  localparam int LAT   = 3;

  localparam int K_RD   = 0;
  localparam int K_WREN = 1;
  localparam int K_PP   = 2;
  localparam int K_POLL = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_rw, ldr_req, ldr_rw;
  logic [23:0] cpu_addr, ldr_addr;
  logic [7:0]  cpu_wdata, ldr_wdata;
  logic        cpu_ack, cpu_err, ldr_ack, ldr_err;
  logic [7:0]  cpu_rdata, ldr_rdata;
  logic        eng_start, eng_done, busy;
  logic [1:0]  eng_op;
  logic [7:0]  eng_cmd, eng_wdata, eng_rdata;
  logic [23:0] eng_addr;
  logic        eng_done_e, spur_done;

  assign eng_done = eng_done_e | spur_done;

  always #5 clk = ~clk;

  spi_flash_scheduler #(.POLL_GAP(GAP), .POLL_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .ldr_req(ldr_req), .ldr_rw(ldr_rw), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata), .ldr_err(ldr_err),
    .eng_start(eng_start), .eng_op(eng_op), .eng_cmd(eng_cmd), .eng_addr(eng_addr),
    .eng_wdata(eng_wdata), .eng_done(eng_done), .eng_rdata(eng_rdata), .busy(busy)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  cmd;
    logic [23:0] addr;
    logic [7:0]  wdata;
    int          cyc;
  } start_t;

  start_t     log_q[$];
  logic [7:0] st_q[$];
  logic [7:0] st_default = 8'h00;
  logic [7:0] rd_val = 8'h00;

  // Engine stand-in: done LAT cycles after each start, status bytes from st_q.
  initial begin
    int cnt;
    int ecyc;
    logic [7:0] pend;
    start_t s;
    cnt = 0; ecyc = 0; pend = 8'h00;
    eng_done_e = 1'b0;
    eng_rdata  = 8'h00;
    forever begin
      @(posedge clk); #1;
      ecyc++;
      eng_done_e = 1'b0;
      if (!reset) begin
        cnt = 0;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          eng_rdata  = pend;
          eng_done_e = 1'b1;
        end
      end else if (eng_start) begin
        s.op = eng_op; s.cmd = eng_cmd; s.addr = eng_addr; s.wdata = eng_wdata; s.cyc = ecyc;
        log_q.push_back(s);
        if (eng_op == 2'd3) pend = (st_q.size() > 0) ? st_q.pop_front() : st_default;
        else pend = rd_val;
        cnt = LAT;
      end
    end
  end

  // Transaction model state.
  int          cyc = 0;
  bit          m_busy, m_pending, m_waiting, m_ackp, m_who, m_err;
  bit          m_rr = 1'b1;
  int          m_kind, m_start_cyc, m_ack_cyc, m_polls;
  logic [23:0] m_addr;
  logic [7:0]  m_wdata;
  logic [7:0]  m_rd_cpu = 8'h00;
  logic [7:0]  m_rd_ldr = 8'h00;

  // Compare process: every cycle, the DUT outputs against the model.
  always @(negedge clk) begin
    bit es, ea, pick;
    logic [1:0] eop;
    logic [7:0] ecmd;
    cyc++;
    if (!reset) begin
      m_busy = 1'b0; m_pending = 1'b0; m_waiting = 1'b0; m_ackp = 1'b0;
      m_rr = 1'b1; m_rd_cpu = 8'h00; m_rd_ldr = 8'h00;
      chk("rst_busy", busy, 32'd0);
      chk("rst_start", eng_start, 32'd0);
      chk("rst_acks", {cpu_ack, cpu_err, ldr_ack, ldr_err}, 32'd0);
      chk("rst_rdata", {cpu_rdata, ldr_rdata}, 32'd0);
    end else begin
      es = m_pending && (cyc == m_start_cyc);
      ea = m_ackp && (cyc == m_ack_cyc);
      chk("busy", busy, m_busy);
      chk("eng_start", eng_start, es);
      chk("acks", {cpu_ack, cpu_err, ldr_ack, ldr_err},
          ea ? {!m_who, !m_who && m_err, m_who, m_who && m_err} : 4'b0000);
      chk("rdata", {cpu_rdata, ldr_rdata}, {m_rd_cpu, m_rd_ldr});
      if (es && eng_start) begin
        case (m_kind)
          K_RD:    begin eop = 2'd1; ecmd = 8'h03; end
          K_WREN:  begin eop = 2'd0; ecmd = 8'h06; end
          K_PP:    begin eop = 2'd2; ecmd = 8'h02; end
          default: begin eop = 2'd3; ecmd = 8'h05; end
        endcase
        chk("eng_op", eng_op, eop);
        chk("eng_cmd", eng_cmd, ecmd);
        if (m_kind == K_RD || m_kind == K_PP) chk("eng_addr", eng_addr, m_addr);
        if (m_kind == K_PP) chk("eng_wdata", eng_wdata, m_wdata);
      end
      if (es) begin
        m_pending = 1'b0;
        m_waiting = 1'b1;
      end
      if (ea) begin
        m_ackp = 1'b0;
        m_busy = 1'b0;
      end else if (!m_busy && (cpu_req || ldr_req)) begin
        pick = ldr_req && (!cpu_req || !m_rr);
        m_rr = pick; m_who = pick; m_err = 1'b0; m_polls = 0;
        m_addr  = pick ? ldr_addr : cpu_addr;
        m_wdata = pick ? ldr_wdata : cpu_wdata;
        m_kind  = (pick ? ldr_rw : cpu_rw) ? K_RD : K_WREN;
        m_busy = 1'b1; m_pending = 1'b1; m_start_cyc = cyc + 1;
      end else if (m_waiting && eng_done && !es) begin
        m_waiting = 1'b0;
        case (m_kind)
          K_RD: begin
            if (m_who) m_rd_ldr = eng_rdata; else m_rd_cpu = eng_rdata;
            m_ackp = 1'b1; m_ack_cyc = cyc + 1;
          end
          K_WREN: begin m_kind = K_PP; m_pending = 1'b1; m_start_cyc = cyc + 1; end
          K_PP:   begin m_kind = K_POLL; m_pending = 1'b1; m_start_cyc = cyc + 1; end
          default: begin
            m_polls++;
            if (!eng_rdata[0]) begin
              m_ackp = 1'b1; m_ack_cyc = cyc + 1;
            end else if (m_polls < LIMIT) begin
              m_pending = 1'b1; m_start_cyc = cyc + 1 + GAP;
            end else begin
              m_ackp = 1'b1; m_ack_cyc = cyc + 1; m_err = 1'b1;
            end
          end
        endcase
      end
    end
  end

  task automatic wait_any(input int bound, output int who, output bit err);
    who = -1;
    err = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk); #1;
      if (cpu_ack) begin who = 0; err = cpu_err; cpu_req = 1'b0; break; end
      if (ldr_ack) begin who = 1; err = ldr_err; ldr_req = 1'b0; break; end
    end
    if (who < 0) begin
      n_chk++;
      $display("FAIL ack_timeout: no ack within %0d cycles", bound);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int who, base, npoll;
    bit err;
    logic [7:0] exp_cmds [5];
    exp_cmds = '{8'h06, 8'h02, 8'h05, 8'h05, 8'h05};
    reset = 1'b1;
    cpu_req = 1'b0; cpu_rw = 1'b0; cpu_addr = 24'h0; cpu_wdata = 8'h0;
    ldr_req = 1'b0; ldr_rw = 1'b0; ldr_addr = 24'h0; ldr_wdata = 8'h0;
    spur_done = 1'b0;
    #2 reset = 1'b0;
    idle(3);
    chk("reset_busy", busy, 32'd0);
    chk("reset_op_cmd", {eng_op, eng_cmd}, 32'd0);
    chk("reset_cpu_rdata", cpu_rdata, 32'd0);
    reset = 1'b1;
    idle(2);

    // CPU read; address moved after grant must not matter
    rd_val = 8'hA5; base = log_q.size();
    cpu_rw = 1'b1; cpu_addr = 24'h000123; cpu_req = 1'b1;
    idle(2);
    cpu_addr = 24'hFFFFFF;
    wait_any(200, who, err);
    chk("t1_who", who, 32'd0);
    chk("t1_err", err, 32'd0);
    chk("t1_rdata", cpu_rdata, 32'hA5);
    chk("t1_nstarts", log_q.size() - base, 32'd1);
    chk("t1_addr", log_q[base].addr, 32'h000123);
    chk("t1_cmd", log_q[base].cmd, 32'h03);
    idle(3);

    // Loader write with two busy polls
    st_q = '{8'h03, 8'h03, 8'h00}; base = log_q.size();
    ldr_rw = 1'b0; ldr_addr = 24'h000456; ldr_wdata = 8'h3C; ldr_req = 1'b1;
    wait_any(300, who, err);
    chk("t2_who", who, 32'd1);
    chk("t2_err", err, 32'd0);
    chk("t2_nstarts", log_q.size() - base, 32'd5);
    for (int i = 0; i < 5; i++) chk("t2_cmd", log_q[base + i].cmd, exp_cmds[i]);
    chk("t2_pp_addr", log_q[base + 1].addr, 32'h000456);
    chk("t2_pp_wdata", log_q[base + 1].wdata, 32'h3C);
    chk("t2_gap1", log_q[base + 3].cyc - log_q[base + 2].cyc, 32'd20);
    chk("t2_gap2", log_q[base + 4].cyc - log_q[base + 3].cyc, 32'd20);
    chk("t2_rdata_keep", ldr_rdata, 32'h00);
    idle(3);

    // Tie after a loader grant: CPU first
    rd_val = 8'h11;
    cpu_rw = 1'b1; cpu_addr = 24'h000010; ldr_rw = 1'b1; ldr_addr = 24'h000020;
    cpu_req = 1'b1; ldr_req = 1'b1;
    wait_any(200, who, err);
    chk("t3_first", who, 32'd0);
    wait_any(200, who, err);
    chk("t3_second", who, 32'd1);
    chk("t3_ldr_rdata", ldr_rdata, 32'h11);
    idle(2);
    rd_val = 8'h22; cpu_req = 1'b1;
    wait_any(200, who, err);
    chk("t3_single", who, 32'd0);
    idle(2);
    // Tie after a CPU grant: loader first
    rd_val = 8'h33; cpu_req = 1'b1; ldr_req = 1'b1;
    wait_any(200, who, err);
    chk("t3b_first", who, 32'd1);
    wait_any(200, who, err);
    chk("t3b_second", who, 32'd0);
    chk("t3b_rdata", {cpu_rdata, ldr_rdata}, 32'h3333);
    idle(3);

    // Status never clears: poll budget exhausted
    st_default = 8'h01; base = log_q.size();
    cpu_rw = 1'b0; cpu_addr = 24'h000789; cpu_wdata = 8'h5A; cpu_req = 1'b1;
    wait_any(600, who, err);
    chk("t4_who", who, 32'd0);
    chk("t4_err", err, 32'd1);
    npoll = 0;
    for (int i = base; i < log_q.size(); i++) if (log_q[i].cmd == 8'h05) npoll++;
    chk("t4_npoll", npoll, 32'd4);
    idle(1);
    chk("t4_busy_after", busy, 32'd0);
    st_default = 8'h00;
    idle(3);

    // Reset during page program
    base = log_q.size();
    ldr_rw = 1'b0; ldr_addr = 24'h0000AA; ldr_wdata = 8'h77; ldr_req = 1'b1;
    for (int i = 0; i < 100; i++) begin
      idle(1);
      if (log_q.size() > base + 1) break;
    end
    chk("t5_pp_seen", log_q.size() - base, 32'd2);
    idle(1);
    reset = 1'b0;
    #1;
    chk("t5_busy", busy, 32'd0);
    chk("t5_start", eng_start, 32'd0);
    chk("t5_acks", {cpu_ack, ldr_ack}, 32'd0);
    ldr_req = 1'b0;
    idle(2);
    reset = 1'b1;
    idle(4);
    rd_val = 8'h44; cpu_rw = 1'b1; cpu_addr = 24'h0000BB; cpu_req = 1'b1;
    wait_any(200, who, err);
    chk("t5_read_who", who, 32'd0);
    chk("t5_read_data", cpu_rdata, 32'h44);
    chk("t5_ldr_rdata", ldr_rdata, 32'h00);
    idle(3);

    // Spurious engine completion while idle
    spur_done = 1'b1;
    idle(1);
    spur_done = 1'b0;
    idle(3);
    chk("t6_busy", busy, 32'd0);
    chk("t6_acks", {cpu_ack, ldr_ack}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
